// File: rtl/cpu_spec_pkg.sv
// Shared definitions for the speculative execution controller, register file and checkpoint logic.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cpu_spec_pkg;

    localparam int NUM_REGS_DEF = 8;
    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HELD    = 2'd1;
    localparam logic [1:0] ST_RESTORE = 2'd2;

endpackage : cpu_spec_pkg

// File: rtl/spec_dirty_prio_enc.sv
// Lowest-set-bit priority encoder over the dirty register mask.
// Latency: purely combinational.
// Backpressure: none.
module spec_dirty_prio_enc
    import cpu_spec_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic [NUM_REGS-1:0] mask,
    output logic [ADDR_W-1:0]   idx,
    output logic                any_set
);

    // Scanning from the top down lets the lowest set bit overwrite the result last.
    always_comb begin
        idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = ADDR_W'(i);
            end
        end
    end

    assign any_set = |mask;

endmodule : spec_dirty_prio_enc

// File: rtl/spec_checkpoint_restore.sv
// Register-file checkpoint: snapshots on take, tracks dirty regs, writes dirty regs back on rollback.
// Latency: rollback with k dirty regs -> writes in cycles T+1..T+k, done pulse at T+k+1.
// Backpressure: no input handshake; restore_busy stalls the pipeline for the whole restore.
module spec_checkpoint_restore
    import cpu_spec_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ckpt_take,
    input  logic                         ckpt_release,
    input  logic                         rollback_req,
    input  logic [NUM_REGS*DATA_W-1:0]   rf_snapshot,
    input  logic                         rf_wr_en,
    input  logic [ADDR_W-1:0]            rf_wr_addr,
    output logic                         restore_wr_en,
    output logic [ADDR_W-1:0]            restore_wr_addr,
    output logic [DATA_W-1:0]            restore_wr_data,
    output logic                         restore_busy,
    output logic                         restore_done,
    output logic                         ckpt_valid,
    output logic [NUM_REGS-1:0]          dirty_mask
);

    logic [1:0]                         state_q;
    logic [NUM_REGS-1:0][DATA_W-1:0]    snap_q;
    logic [ADDR_W-1:0]                  enc_idx;
    logic                               enc_any;
    logic [NUM_REGS-1:0]                wr_onehot;
    logic [NUM_REGS-1:0]                clr_onehot;
    logic                               in_restore;

    spec_dirty_prio_enc #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_prio_enc (
        .mask    (dirty_mask),
        .idx     (enc_idx),
        .any_set (enc_any)
    );

    assign in_restore = (state_q == ST_RESTORE);
    assign wr_onehot  = rf_wr_en ? (NUM_REGS'(1) << rf_wr_addr) : '0;
    assign clr_onehot = NUM_REGS'(1) << enc_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            snap_q     <= '0;
            dirty_mask <= '0;
            ckpt_valid <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ckpt_take) begin
                        snap_q     <= rf_snapshot;
                        dirty_mask <= wr_onehot;
                        ckpt_valid <= 1'b1;
                        state_q    <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (rollback_req) begin
                        dirty_mask <= dirty_mask | wr_onehot;
                        state_q    <= ST_RESTORE;
                    end else if (ckpt_take) begin
                        // Snapshot holds the pre-write value; a same-cycle write is dirty.
                        snap_q     <= rf_snapshot;
                        dirty_mask <= wr_onehot;
                    end else if (ckpt_release) begin
                        dirty_mask <= '0;
                        ckpt_valid <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        dirty_mask <= dirty_mask | wr_onehot;
                    end
                end
                ST_RESTORE: begin
                    if (enc_any) begin
                        dirty_mask <= dirty_mask & ~clr_onehot;
                    end else begin
                        ckpt_valid <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from registered state so an async reset silences them at once.
    always_comb begin
        restore_wr_en   = 1'b0;
        restore_wr_addr = '0;
        restore_wr_data = '0;
        restore_busy    = in_restore;
        restore_done    = in_restore && !enc_any;
        if (in_restore && enc_any) begin
            restore_wr_en   = 1'b1;
            restore_wr_addr = enc_idx;
            restore_wr_data = snap_q[enc_idx];
        end
    end

endmodule : spec_checkpoint_restore
